// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared core definitions: load/store size codes, LSU FSM states
//               and the byte-enable helper used by the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    // Byte lanes touched by an access; signedness does not change the lanes.
    function automatic logic [3:0] lsu_byte_en(input logic [2:0] size, input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            LDST_B, LDST_BU: be = 4'b0001 << offset;
            LDST_H, LDST_HU: be = 4'b0011 << offset;
            default:         be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_ext.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_ext
// Description : Selects the byte/halfword lane of a read word and sign- or
//               zero-extends it to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_ext
    import riscv_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [2:0]  i_size,
    input  logic [1:0]  i_offset,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_data = i_rdata;
        case (i_size)
            LDST_B:  o_data = {{24{w_byte[7]}}, w_byte};
            LDST_BU: o_data = {24'd0, w_byte};
            LDST_H:  o_data = {{16{w_half[15]}}, w_half};
            LDST_HU: o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_riscv.sv
`default_nettype none
// ============================================================================
// Module      : lsu_riscv
// Description : Load/store unit bridging the core's memory request to a
//               req/gnt/rvalid data bus, with alignment checks and load extension.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_riscv
    import riscv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_err_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    lsu_state_e  r_state;
    lsu_state_e  w_state_next;

    logic [31:0] r_addr;
    logic        r_we;
    logic [2:0]  r_size;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_load_data;

    logic        w_err;
    logic        w_accept;
    logic [31:0] w_wdata;
    logic [31:0] w_load_ext;

    always_comb begin
        w_err = 1'b0;
        case (lsu_size_i)
            LDST_B:  w_err = 1'b0;
            LDST_H:  w_err = lsu_addr_i[0];
            LDST_W:  w_err = |lsu_addr_i[1:0];
            LDST_BU: w_err = lsu_we_i;
            LDST_HU: w_err = lsu_we_i | lsu_addr_i[0];
            default: w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_wdata = lsu_data_i;
        case (lsu_size_i)
            LDST_B, LDST_BU: w_wdata = {4{lsu_data_i[7:0]}};
            LDST_H, LDST_HU: w_wdata = {2{lsu_data_i[15:0]}};
            default:         w_wdata = lsu_data_i;
        endcase
    end

    assign w_accept = (r_state == LSU_IDLE) && lsu_req_i && !w_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= LSU_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LSU_IDLE: if (w_accept)      w_state_next = LSU_REQ;
            LSU_REQ:  if (data_gnt_i)    w_state_next = r_we ? LSU_DONE : LSU_RESP;
            LSU_RESP: if (data_rvalid_i) w_state_next = LSU_DONE;
            default:                     w_state_next = LSU_IDLE;
        endcase
    end

    always_comb begin
        data_req_o      = (r_state == LSU_REQ);
        lsu_stall_req_o = lsu_req_i && !w_err && (r_state != LSU_DONE);
        lsu_err_o       = w_err;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_size  <= LDST_B;
            r_be    <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_addr  <= lsu_addr_i;
            r_we    <= lsu_we_i;
            r_size  <= lsu_size_i;
            r_be    <= lsu_byte_en(lsu_size_i, lsu_addr_i[1:0]);
            r_wdata <= w_wdata;
        end
    end

    lsu_load_ext u_load_ext (
        .i_rdata  (data_rdata_i),
        .i_size   (r_size),
        .i_offset (r_addr[1:0]),
        .o_data   (w_load_ext)
    );

    // Only a response arriving in RESP belongs to the current load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_load_data <= '0;
        end else if ((r_state == LSU_RESP) && data_rvalid_i) begin
            r_load_data <= w_load_ext;
        end
    end

    assign lsu_data_o   = r_load_data;
    assign data_we_o    = r_we;
    assign data_be_o    = r_be;
    assign data_addr_o  = {r_addr[31:2], 2'b00};
    assign data_wdata_o = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_riscv.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_riscv
// Description : Directed self-checking bench for lsu_riscv.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_riscv;

    localparam logic [2:0] SZ_B = 3'd0, SZ_H = 3'd1, SZ_W = 3'd2, SZ_BU = 3'd4, SZ_HU = 3'd5;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        lsu_req_i = 1'b0;
    logic        lsu_we_i = 1'b0;
    logic [2:0]  lsu_size_i = 3'd0;
    logic [31:0] lsu_addr_i = '0;
    logic [31:0] lsu_data_i = '0;
    logic [31:0] lsu_data_o;
    logic        lsu_stall_req_o;
    logic        lsu_err_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i = 1'b0;
    logic        data_rvalid_i = 1'b0;
    logic [31:0] data_rdata_i = '0;

    int checks = 0;
    int errors = 0;

    int          stall_cyc, req_cyc, rel_rv;
    logic [3:0]  be_s;
    logic [31:0] addr_s, wdata_s;
    logic        we_s;
    bit          tmo;

    always #5 clk_i = ~clk_i;

    lsu_riscv dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .lsu_req_i       (lsu_req_i),
        .lsu_we_i        (lsu_we_i),
        .lsu_size_i      (lsu_size_i),
        .lsu_addr_i      (lsu_addr_i),
        .lsu_data_i      (lsu_data_i),
        .lsu_data_o      (lsu_data_o),
        .lsu_stall_req_o (lsu_stall_req_o),
        .lsu_err_o       (lsu_err_o),
        .data_req_o      (data_req_o),
        .data_we_o       (data_we_o),
        .data_be_o       (data_be_o),
        .data_addr_o     (data_addr_o),
        .data_wdata_o    (data_wdata_o),
        .data_gnt_i      (data_gnt_i),
        .data_rvalid_i   (data_rvalid_i),
        .data_rdata_i    (data_rdata_i)
    );

    // Core + memory model for one access; entered and left at posedge+1 with the DUT idle.
    task automatic run_txn(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int gnt_wait, input int rv_wait);
        int  rv_cyc;
        int  wait_cnt;
        bit  granted;
        rv_cyc = -100; wait_cnt = 0; granted = 0;
        stall_cyc = 0; req_cyc = 0; rel_rv = -1; tmo = 1;
        be_s = '0; addr_s = '0; wdata_s = '0; we_s = 1'b0;
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size;
        lsu_addr_i = addr; lsu_data_i = wdata; data_rdata_i = rdata;
        for (int c = 0; c < 40; c++) begin
            data_gnt_i = data_req_o && (req_cyc == gnt_wait);
            if (data_req_o) begin
                req_cyc++;
                be_s = data_be_o; addr_s = data_addr_o; wdata_s = data_wdata_o; we_s = data_we_o;
            end
            data_rvalid_i = granted && (wait_cnt == rv_wait);
            if (data_rvalid_i) begin
                rv_cyc = c;
                granted = 0;
            end else if (granted) begin
                wait_cnt++;
            end
            #1;
            if (!lsu_stall_req_o) begin
                rel_rv = c - rv_cyc;
                tmo = 0;
                break;
            end
            stall_cyc++;
            if (data_gnt_i && !we) granted = 1;
            @(posedge clk_i); #1;
        end
        @(posedge clk_i); #1;
        lsu_req_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        #1;
        checks++; if (data_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", data_req_o); end
        checks++; if (data_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", data_we_o); end
        checks++; if (data_be_o !== 4'h0) begin errors++; $display("FAIL reset_be got=%h exp=0", data_be_o); end
        checks++; if (data_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", data_addr_o); end
        checks++; if (data_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", data_wdata_o); end
        checks++; if (lsu_data_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", lsu_data_o); end
        checks++; if (lsu_stall_req_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", lsu_stall_req_o); end
    endtask

    task automatic test_store_word();
        run_txn(1'b1, SZ_W, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
        checks++; if (tmo) begin errors++; $display("FAIL sw_timeout got=1 exp=0"); end
        checks++; if (stall_cyc !== 2) begin errors++; $display("FAIL sw_stall got=%0d exp=2", stall_cyc); end
        checks++; if (req_cyc !== 1) begin errors++; $display("FAIL sw_req_cycles got=%0d exp=1", req_cyc); end
        checks++; if (addr_s !== 32'h100) begin errors++; $display("FAIL sw_addr got=%h exp=00000100", addr_s); end
        checks++; if (be_s !== 4'b1111) begin errors++; $display("FAIL sw_be got=%b exp=1111", be_s); end
        checks++; if (wdata_s !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got=%h exp=deadbeef", wdata_s); end
        checks++; if (we_s !== 1'b1) begin errors++; $display("FAIL sw_we got=%b exp=1", we_s); end
        checks++; if (data_req_o !== 1'b0) begin errors++; $display("FAIL sw_idle_req got=%b exp=0", data_req_o); end
    endtask

    task automatic test_store_byte();
        run_txn(1'b1, SZ_B, 32'h103, 32'h000000A5, 32'h0, 0, 0);
        checks++; if (be_s !== 4'b1000) begin errors++; $display("FAIL sb_be got=%b exp=1000", be_s); end
        checks++; if (wdata_s !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", wdata_s); end
        checks++; if (addr_s !== 32'h100) begin errors++; $display("FAIL sb_addr got=%h exp=00000100", addr_s); end
        run_txn(1'b1, SZ_H, 32'h102, 32'h1234BEEF, 32'h0, 0, 0);
        checks++; if (be_s !== 4'b1100) begin errors++; $display("FAIL sh_be got=%b exp=1100", be_s); end
        checks++; if (wdata_s !== 32'hBEEFBEEF) begin errors++; $display("FAIL sh_wdata got=%h exp=beefbeef", wdata_s); end
    endtask

    task automatic test_load_byte();
        run_txn(1'b0, SZ_B, 32'h201, 32'h0, 32'h0000F300, 0, 0);
        checks++; if (tmo) begin errors++; $display("FAIL lb_timeout got=1 exp=0"); end
        checks++; if (stall_cyc !== 3) begin errors++; $display("FAIL lb_stall got=%0d exp=3", stall_cyc); end
        checks++; if (be_s !== 4'b0010) begin errors++; $display("FAIL lb_be got=%b exp=0010", be_s); end
        checks++; if (addr_s !== 32'h200) begin errors++; $display("FAIL lb_addr got=%h exp=00000200", addr_s); end
        checks++; if (we_s !== 1'b0) begin errors++; $display("FAIL lb_we got=%b exp=0", we_s); end
        checks++; if (lsu_data_o !== 32'hFFFFFFF3) begin errors++; $display("FAIL lb_data got=%h exp=fffffff3", lsu_data_o); end
        run_txn(1'b0, SZ_BU, 32'h201, 32'h0, 32'h0000F300, 0, 0);
        checks++; if (lsu_data_o !== 32'h000000F3) begin errors++; $display("FAIL lbu_data got=%h exp=000000f3", lsu_data_o); end
        run_txn(1'b0, SZ_B, 32'h203, 32'h0, 32'h7F000000, 0, 0);
        checks++; if (lsu_data_o !== 32'h0000007F) begin errors++; $display("FAIL lb3_data got=%h exp=0000007f", lsu_data_o); end
    endtask

    task automatic test_load_half();
        run_txn(1'b0, SZ_HU, 32'h202, 32'h0, 32'h80011234, 0, 0);
        checks++; if (lsu_data_o !== 32'h00008001) begin errors++; $display("FAIL lhu_data got=%h exp=00008001", lsu_data_o); end
        checks++; if (be_s !== 4'b1100) begin errors++; $display("FAIL lhu_be got=%b exp=1100", be_s); end
        run_txn(1'b0, SZ_H, 32'h202, 32'h0, 32'h80011234, 0, 0);
        checks++; if (lsu_data_o !== 32'hFFFF8001) begin errors++; $display("FAIL lh_data got=%h exp=ffff8001", lsu_data_o); end
        run_txn(1'b0, SZ_H, 32'h200, 32'h0, 32'h80011234, 0, 0);
        checks++; if (lsu_data_o !== 32'h00001234) begin errors++; $display("FAIL lh0_data got=%h exp=00001234", lsu_data_o); end
    endtask

    task automatic test_hold();
        run_txn(1'b1, SZ_W, 32'h300, 32'h55AA55AA, 32'hFFFFFFFF, 0, 0);
        checks++; if (lsu_data_o !== 32'h00001234) begin errors++; $display("FAIL hold_after_store got=%h exp=00001234", lsu_data_o); end
        data_rvalid_i = 1'b1; data_rdata_i = 32'hFFFFFFFF;
        @(posedge clk_i); #1;
        data_rvalid_i = 1'b0;
        checks++; if (lsu_data_o !== 32'h00001234) begin errors++; $display("FAIL hold_stray_rvalid got=%h exp=00001234", lsu_data_o); end
    endtask

    task automatic test_back_to_back();
        run_txn(1'b0, SZ_W, 32'h400, 32'h0, 32'h12345678, 3, 2);
        checks++; if (tmo) begin errors++; $display("FAIL bp_timeout got=1 exp=0"); end
        checks++; if (req_cyc !== 4) begin errors++; $display("FAIL bp_req_cycles got=%0d exp=4", req_cyc); end
        checks++; if (rel_rv !== 1) begin errors++; $display("FAIL bp_release_after_rvalid got=%0d exp=1", rel_rv); end
        checks++; if (stall_cyc !== 8) begin errors++; $display("FAIL bp_stall got=%0d exp=8", stall_cyc); end
        checks++; if (lsu_data_o !== 32'h12345678) begin errors++; $display("FAIL bp_data got=%h exp=12345678", lsu_data_o); end
        run_txn(1'b1, SZ_W, 32'h404, 32'hCAFEF00D, 32'h0, 2, 0);
        checks++; if (req_cyc !== 3) begin errors++; $display("FAIL bp_st_req_cycles got=%0d exp=3", req_cyc); end
        checks++; if (stall_cyc !== 4) begin errors++; $display("FAIL bp_st_stall got=%0d exp=4", stall_cyc); end
    endtask

    task automatic test_errors();
        logic        t_we  [12] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0};
        logic [2:0]  t_sz  [12] = '{SZ_W, SZ_H, SZ_HU, 3'd3, 3'd6, 3'd7, SZ_BU, SZ_HU, SZ_BU, SZ_B, SZ_H, SZ_W};
        logic [31:0] t_ad  [12] = '{32'h102, 32'h101, 32'h103, 32'h100, 32'h100, 32'h100,
                                    32'h100, 32'h100, 32'h103, 32'h103, 32'h102, 32'h104};
        logic        t_err [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        for (int i = 0; i < 12; i++) begin
            lsu_req_i = 1'b1; lsu_we_i = t_we[i]; lsu_size_i = t_sz[i]; lsu_addr_i = t_ad[i];
            #1;
            checks++; if (lsu_err_o !== t_err[i]) begin errors++; $display("FAIL err_row%0d got=%b exp=%b", i, lsu_err_o, t_err[i]); end
            checks++; if (lsu_stall_req_o !== !t_err[i]) begin errors++; $display("FAIL err_stall_row%0d got=%b exp=%b", i, lsu_stall_req_o, !t_err[i]); end
            if (t_err[i]) begin
                repeat (2) begin
                    @(posedge clk_i); #1;
                    checks++; if (data_req_o !== 1'b0) begin errors++; $display("FAIL err_noreq_row%0d got=%b exp=0", i, data_req_o); end
                end
            end
            lsu_req_i = 1'b0;
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_reset_in_resp();
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = SZ_W; lsu_addr_i = 32'h500;
        data_rdata_i = 32'h0;
        @(posedge clk_i); #1;
        checks++; if (data_req_o !== 1'b1) begin errors++; $display("FAIL rr_req got=%b exp=1", data_req_o); end
        data_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        data_gnt_i = 1'b0;
        checks++; if (data_req_o !== 1'b0) begin errors++; $display("FAIL rr_resp_req got=%b exp=0", data_req_o); end
        rst_i = 1'b1; lsu_req_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        checks++; if (lsu_data_o !== 32'h0) begin errors++; $display("FAIL rr_rdata got=%h exp=0", lsu_data_o); end
        checks++; if (data_addr_o !== 32'h0) begin errors++; $display("FAIL rr_addr got=%h exp=0", data_addr_o); end
        checks++; if (data_be_o !== 4'h0) begin errors++; $display("FAIL rr_be got=%h exp=0", data_be_o); end
        checks++; if (data_wdata_o !== 32'h0) begin errors++; $display("FAIL rr_wdata got=%h exp=0", data_wdata_o); end
        data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFEF00D;
        repeat (2) @(posedge clk_i);
        #1 data_rvalid_i = 1'b0;
        checks++; if (lsu_data_o !== 32'h0) begin errors++; $display("FAIL rr_late_rvalid got=%h exp=0", lsu_data_o); end
        checks++; if (data_req_o !== 1'b0) begin errors++; $display("FAIL rr_idle_req got=%b exp=0", data_req_o); end
        run_txn(1'b0, SZ_BU, 32'h502, 32'h0, 32'h00AB0000, 0, 0);
        checks++; if (lsu_data_o !== 32'h000000AB) begin errors++; $display("FAIL rr_recover got=%h exp=000000ab", lsu_data_o); end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_byte();
        test_load_byte();
        test_load_half();
        test_hold();
        test_back_to_back();
        test_errors();
        test_reset_in_resp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
